// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller of a synchronous FIFO. Owns the read pointer, issues
// one-cycle read pulses to a synchronous-read RAM and presents each fetched
// word on a registered valid/ready output stage.
//
// Pointers are ADDR_W+1 bits wide. The extra MSB is a wrap bit, so
// level = wr_ptr - rd_ptr (mod 2**(ADDR_W+1)) tells "full" (level == depth)
// apart from "empty" (level == 0).
//
// Optional feature macro: FIFO_RD_FLUSH_EN
//   When defined, an rd_flush input is added. A flush snaps rd_ptr to wr_ptr,
//   drops the output word and returns the FSM to IDLE. Reset beats flush;
//   flush beats every normal FSM transition. When the macro is undefined the
//   port and all of its logic are absent.
//
// Handshake (output side): a word moves to the consumer on a rising edge where
// dout_vld & dout_rdy are both 1. While dout_vld=1 and dout_rdy=0, dout and
// dout_vld stay unchanged. dout_vld never depends combinationally on dout_rdy.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst_n      in   1         synchronous active-low reset
//   rd_flush   in   1         (FIFO_RD_FLUSH_EN only) discard unread contents
//   wr_ptr     in   ADDR_W+1  write pointer from the write side
//   rd_ptr     out  ADDR_W+1  read pointer, returned to the write side
//   ram_re     out  1         RAM read enable (combinational, one-cycle pulse)
//   ram_raddr  out  ADDR_W    RAM read address = rd_ptr[ADDR_W-1:0]
//   ram_rdata  in   DATA_W    RAM read data, valid one cycle after ram_re
//   dout       out  DATA_W    output word (registered)
//   dout_vld   out  1         dout holds a word (registered)
//   dout_rdy   in   1         consumer ready
//   level      out  ADDR_W+1  words in RAM not yet fetched (combinational)
//   empty      out  1         level == 0 (combinational)
//   ptr_err    out  1         sticky: a level above the RAM depth was seen
//   state_dbg  out  2         current FSM state (0 IDLE, 1 FETCH, 2 VALID)
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef FIFO_RD_FLUSH_EN
  input  logic              rd_flush,
`endif
  input  logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              ptr_err,
  output logic [1:0]        state_dbg
);

  localparam int PW = ADDR_W + 1;

  // RAM depth expressed in pointer width: wrap bit set, address bits clear.
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [PW-1:0]     rd_ptr_q,  rd_ptr_d;
  logic [DATA_W-1:0] dout_q,    dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              ptr_err_q, ptr_err_d;

  logic [PW-1:0]     level_c;
  logic              level_nz;
  logic              ram_re_c;
  logic              flush_c;

  // -------------------------------------------------------------------------
  // Flush request (constant 0 when the feature is not built)
  // -------------------------------------------------------------------------
`ifdef FIFO_RD_FLUSH_EN
  assign flush_c = rd_flush;
`else
  assign flush_c = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Fill level: two's-complement subtraction, truncated to pointer width so
  // the wrap bit makes the difference correct across pointer wrap-around.
  // -------------------------------------------------------------------------
  assign level_c  = wr_ptr + ~rd_ptr_q + PW'(1);
  assign level_nz = (level_c != '0);

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    ram_re_c   = 1'b0;
    // Sticky error: anything above the RAM depth means the pointers disagree.
    ptr_err_d  = ptr_err_q | (level_c > DEPTH);

    case (state_q)
      ST_IDLE: begin
        dout_vld_d = 1'b0;
        if (level_nz) begin
          ram_re_c = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
          state_d  = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // RAM data for the read issued last cycle is on ram_rdata now.
        dout_d     = ram_rdata;
        dout_vld_d = 1'b1;
        state_d    = ST_VALID;
      end

      ST_VALID: begin
        if (dout_rdy) begin
          dout_vld_d = 1'b0;
          if (level_nz) begin
            // Overlap the next fetch with the handshake to save a cycle.
            ram_re_c = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        dout_vld_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // Flush overrides every transition above, including a read in progress.
    if (flush_c) begin
      ram_re_c   = 1'b0;
      rd_ptr_d   = wr_ptr;
      dout_vld_d = 1'b0;
      state_d    = ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ptr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ptr_err_q  <= ptr_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // ram_re is forced low during reset so no read is issued while the pointer
  // is being cleared.
  assign ram_re    = ram_re_c & rst_n;
  assign ram_raddr = rd_ptr_q[ADDR_W-1:0];
  assign rd_ptr    = rd_ptr_q;
  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign level     = level_c;
  assign empty     = ~level_nz;
  assign ptr_err   = ptr_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Directed bench for fifo_rd_ctrl. A behavioural sync-read RAM sits behind
// the DUT. Stimulus writes a word into the RAM model, advances wr_ptr and
// pushes the word onto exp_q; a separate monitor pops exp_q whenever the DUT
// completes an output handshake. Directed checks cover reset, latency,
// backpressure, pointer wrap, the overflow flag and (with FIFO_RD_FLUSH_EN)
// flush.
// ---------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_rdy;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              ptr_err;
  logic [1:0]        state_dbg;
`ifdef FIFO_RD_FLUSH_EN
  logic              rd_flush;
`endif

  fifo_rd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FIFO_RD_FLUSH_EN
    .rd_flush  (rd_flush),
`endif
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .level     (level),
    .empty     (empty),
    .ptr_err   (ptr_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- RAM model (sync read) ----------------
  logic [DATA_W-1:0] mem [16];
  initial ram_rdata = '0;
  always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_raddr];

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  int                pop_cyc[$];
  logic [ADDR_W-1:0] addr_log[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  bit                mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, after inputs for the cycle have settled.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && mon_en) begin
        if (ram_re) addr_log.push_back(ram_raddr);
        if (dout_vld && dout_rdy) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_unexpected: got %0h expected none (t=%0t)", dout, $time);
          end else begin
            chk("pop_data", 32'(dout), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    mem[wr_ptr[ADDR_W-1:0]] = d;
    wr_ptr = wr_ptr + 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic do_reset(input logic [ADDR_W:0] w);
    rst_n = 1'b0;
    wr_ptr = w;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !dout_vld && state_dbg == 2'd0) break;
      tick();
    end
    if (i == limit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    wr_ptr   = '0;
    dout_rdy = 1'b0;
`ifdef FIFO_RD_FLUSH_EN
    rd_flush = 1'b0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // 1: reset with wr_ptr = 7
    do_reset(5'd7);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_dout_vld", 32'(dout_vld), 32'd0);
    chk("rst_ptr_err", 32'(ptr_err), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_level", 32'(level), 32'd7);
    wr_ptr = '0;  // stop the DUT from reading before the clean restart

    // 2: single word, latency
    do_reset(5'd0);
    mon_en   = 1'b1;
    dout_rdy = 1'b1;
    push_word(8'hA5);
    #1;
    chk("t0_ram_re", 32'(ram_re), 32'd1);
    chk("t0_raddr", 32'(ram_raddr), 32'd0);
    tick();
    chk("t1_dout_vld", 32'(dout_vld), 32'd0);
    chk("t1_ram_re", 32'(ram_re), 32'd0);
    tick();
    chk("t2_dout_vld", 32'(dout_vld), 32'd1);
    chk("t2_dout", 32'(dout), 32'hA5);
    tick();
    chk("t3_dout_vld", 32'(dout_vld), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_rd_ptr", 32'(rd_ptr), 32'd1);
    chk("t3_idle", 32'(state_dbg), 32'd0);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: backpressure then release
    do_reset(5'd0);
    dout_rdy = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (5) tick();
    chk("bp_dout_vld", 32'(dout_vld), 32'd1);
    chk("bp_dout", 32'(dout), 32'h11);
    chk("bp_rd_ptr", 32'(rd_ptr), 32'd1);
    pop_cyc.delete();
    dout_rdy = 1'b1;
    drain(40);
    chk("bp_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("bp_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
      chk("bp_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
    end

    // 4: wrap; walk rd_ptr to 30 with three batches of 10
    do_reset(5'd0);
    dout_rdy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 10; k++) push_word(8'(8'h40 + b * 10 + k));
      drain(60);
    end
    chk("wr_rd_ptr30", 32'(rd_ptr), 32'd30);
    addr_log.delete();
    push_word(8'hC0);
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    #1;
    chk("wr_level4", 32'(level), 32'd4);
    drain(40);
    chk("wr_nreads", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      chk("wr_addr0", 32'(addr_log[0]), 32'd14);
      chk("wr_addr1", 32'(addr_log[1]), 32'd15);
      chk("wr_addr2", 32'(addr_log[2]), 32'd0);
      chk("wr_addr3", 32'(addr_log[3]), 32'd1);
    end
    chk("wr_rd_ptr2", 32'(rd_ptr), 32'd2);
    chk("wr_empty", 32'(empty), 32'd1);

    // 5: full level and sticky overflow flag (data not scored here)
    mon_en   = 1'b0;
    dout_rdy = 1'b0;
    do_reset(5'd16);
    chk("fe_level16", 32'(level), 32'd16);
    chk("fe_err0", 32'(ptr_err), 32'd0);
    tick();
    chk("fe_err_still0", 32'(ptr_err), 32'd0);
    chk("fe_read_proceeds", 32'(rd_ptr), 32'd1);
    wr_ptr = 5'd18;  // rd_ptr is 1, so level = 17
    #1;
    chk("fe_level17", 32'(level), 32'd17);
    tick();
    chk("fe_err1", 32'(ptr_err), 32'd1);
    wr_ptr = 5'd1;
    repeat (4) tick();
    chk("fe_err_sticky", 32'(ptr_err), 32'd1);

`ifdef FIFO_RD_FLUSH_EN
    // 6: flush while holding a word with five more unread
    do_reset(5'd0);
    mon_en   = 1'b1;
    dout_rdy = 1'b0;
    for (int k = 0; k < 6; k++) push_word(8'(8'h70 + k));
    repeat (3) tick();
    chk("fl_pre_vld", 32'(dout_vld), 32'd1);
    chk("fl_pre_level", 32'(level), 32'd5);
    rd_flush = 1'b1;
    #1;
    chk("fl_no_read", 32'(ram_re), 32'd0);
    tick();
    rd_flush = 1'b0;
    exp_q.delete();
    chk("fl_rd_ptr", 32'(rd_ptr), 32'd6);
    chk("fl_dout_vld", 32'(dout_vld), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    dout_rdy = 1'b1;
    repeat (3) tick();
    chk("fl_stays_idle", 32'(dout_vld), 32'd0);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
